// File: rtl/seg7_step_display.sv
// rtl/seg7_step_display.sv - divider-driven 4-bit up/down counter with seven-segment output
module seg7_step_display #(
    parameter int unsigned MAX_VAL = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       div_in,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out
);

    localparam logic [3:0] MAX_CNT = MAX_VAL[3:0];

    localparam logic [0:0] ST_PAUSED  = 1'b0;
    localparam logic [0:0] ST_RUNNING = 1'b1;

    logic [7:0] ui_meta;
    logic [7:0] ui_s;
    logic       ld_q;
    logic       div_q;
    logic [0:0] state;
    logic [3:0] count;
    logic       dp;

    logic       load;
    logic       step;
    logic [3:0] load_val;
    logic [3:0] count_nxt;
    logic       dp_nxt;

    // Hex digit to active-high segments, a in bit 0
    function automatic logic [6:0] seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Two-flop synchroniser for the asynchronous switches, plus load-edge history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ui_meta <= 8'h00;
            ui_s    <= 8'h00;
            ld_q    <= 1'b0;
        end else begin
            ui_meta <= ui_in;
            ui_s    <= ui_meta;
            ld_q    <= ui_s[2];
        end
    end

    // Previous divider level; div_in is already in the clk domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_in;
        end
    end

    assign load = ui_s[2] & ~ld_q;
    assign step = div_in & ~div_q;

    // Loaded values above the wrap point are clipped to it
    assign load_val = (ui_s[7:4] > MAX_CNT) ? MAX_CNT : ui_s[7:4];

    // Run/pause state simply follows the synchronised run switch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_PAUSED;
        end else begin
            state <= ui_s[0] ? ST_RUNNING : ST_PAUSED;
        end
    end

    // Next count: load beats step; steps wrap modulo MAX_VAL+1 and flag the wrap on dp
    always_comb begin
        count_nxt = count;
        dp_nxt    = dp;
        if (load) begin
            count_nxt = load_val;
            dp_nxt    = 1'b0;
        end else if (step && (state == ST_RUNNING)) begin
            if (!ui_s[1]) begin
                if (count == MAX_CNT) begin
                    count_nxt = 4'd0;
                    dp_nxt    = 1'b1;
                end else begin
                    count_nxt = count + 4'd1;
                    dp_nxt    = 1'b0;
                end
            end else begin
                if (count == 4'd0) begin
                    count_nxt = MAX_CNT;
                    dp_nxt    = 1'b1;
                end else begin
                    count_nxt = count - 4'd1;
                    dp_nxt    = 1'b0;
                end
            end
        end
    end

    // Counter and wrap flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 4'd0;
            dp    <= 1'b0;
        end else begin
            count <= count_nxt;
            dp    <= dp_nxt;
        end
    end

    // Registered display; blanking only masks the output, counting continues
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uo_out <= 8'h00;
        end else if (ui_s[3]) begin
            uo_out <= 8'h00;
        end else begin
            uo_out <= {dp, seg(count)};
        end
    end

endmodule

// File: tb/tb_seg7_step_display.sv
// tb/tb_seg7_step_display.sv - self-checking bench for seg7_step_display
module tb_seg7_step_display;

    logic       clk;
    logic       rst_n;
    logic       div_in;
    logic [7:0] ui_in;
    logic [7:0] uo15;
    logic [7:0] uo9;

    int n_tests;
    int n_fail;

    localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_step_display #(.MAX_VAL(15)) dut15 (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_in (div_in),
        .ui_in  (ui_in),
        .uo_out (uo15)
    );

    seg7_step_display #(.MAX_VAL(9)) dut9 (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_in (div_in),
        .ui_in  (ui_in),
        .uo_out (uo9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: switch values as seen at the last three edges, counter per wrap value
    logic [7:0]  h1, h2, h3;
    logic        div_prev;
    int unsigned maxv [2];
    int unsigned m_cnt [2];
    logic        m_dp [2];
    logic [7:0]  m_uo [2];

    task automatic tick();
        logic ld, run, stp;
        int unsigned lv;
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                m_cnt[m] = 0;
                m_dp[m]  = 1'b0;
                m_uo[m]  = 8'h00;
            end else begin
                ld  = h2[2] && !h3[2];
                run = h3[0];
                stp = div_in && !div_prev;
                m_uo[m] = h2[3] ? 8'h00 : {m_dp[m], SEG[m_cnt[m]]};
                if (ld) begin
                    lv = int'(h2[7:4]);
                    m_cnt[m] = (lv > maxv[m]) ? maxv[m] : lv;
                    m_dp[m]  = 1'b0;
                end else if (stp && run) begin
                    if (!h2[1]) begin
                        m_dp[m]  = (m_cnt[m] == maxv[m]);
                        m_cnt[m] = (m_cnt[m] + 1) % (maxv[m] + 1);
                    end else begin
                        m_dp[m]  = (m_cnt[m] == 0);
                        m_cnt[m] = (m_cnt[m] + maxv[m]) % (maxv[m] + 1);
                    end
                end
            end
        end
        if (!rst_n) begin
            h1 = 8'h00; h2 = 8'h00; h3 = 8'h00;
            div_prev = 1'b0;
        end else begin
            h3 = h2; h2 = h1; h1 = ui_in;
            div_prev = div_in;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        div_in = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ui_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            div_in = ~div_in;
            tick();
            n_tests++;
            if (uo15 !== 8'h00 || uo9 !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got %h/%h want 00/00", i, uo15, uo9);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            div_in = ~div_in;
            tick();
            n_tests++;
            if (uo15 !== 8'h3F || uo9 !== 8'h3F) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %h/%h want 3f/3f", i, uo15, uo9);
            end
        end
    endtask

    task automatic test_count_up();
        logic [7:0] exp15;
        do_reset();
        ui_in = 8'h01;
        repeat (4) tick();
        for (int i = 1; i <= 17; i++) begin
            div_in = 1'b1;
            tick();
            div_in = 1'b0;
            tick();
            exp15 = (i == 16) ? 8'hBF : {1'b0, SEG[i % 16]};
            n_tests++;
            if (uo15 !== exp15) begin
                n_fail++;
                $display("FAIL count_up15 step %0d: got %h want %h", i, uo15, exp15);
            end
            n_tests++;
            if (uo9 !== m_uo[1]) begin
                n_fail++;
                $display("FAIL count_up9 step %0d: got %h want %h", i, uo9, m_uo[1]);
            end
        end
    endtask

    task automatic test_count_down();
        do_reset();
        ui_in = 8'h03;
        repeat (4) tick();
        div_in = 1'b1; tick(); div_in = 1'b0; tick();
        n_tests++;
        if (uo9 !== 8'hEF || uo15 !== 8'hF1) begin
            n_fail++;
            $display("FAIL count_down_wrap: got %h/%h want ef/f1", uo9, uo15);
        end
        div_in = 1'b1; tick(); div_in = 1'b0; tick();
        n_tests++;
        if (uo9 !== 8'h7F || uo15 !== 8'h79) begin
            n_fail++;
            $display("FAIL count_down_next: got %h/%h want 7f/79", uo9, uo15);
        end
    endtask

    task automatic test_load();
        do_reset();
        ui_in = 8'h41;
        repeat (4) tick();
        ui_in = 8'h45;
        tick();
        tick();
        div_in = 1'b1;
        tick();
        div_in = 1'b0;
        tick();
        n_tests++;
        if (uo9 !== 8'h66 || uo15 !== 8'h66) begin
            n_fail++;
            $display("FAIL load_over_step: got %h/%h want 66/66", uo9, uo15);
        end
        ui_in = 8'hC1;
        repeat (4) tick();
        ui_in = 8'hC5;
        repeat (4) tick();
        n_tests++;
        if (uo9 !== 8'h6F || uo15 !== 8'h39) begin
            n_fail++;
            $display("FAIL load_clip: got %h/%h want 6f/39", uo9, uo15);
        end
        ui_in = 8'h21;
        repeat (4) tick();
        ui_in = 8'h25;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            div_in = 1'b1; tick(); div_in = 1'b0; tick();
        end
        n_tests++;
        if (uo9 !== 8'h6D || uo15 !== 8'h6D) begin
            n_fail++;
            $display("FAIL load_held: got %h/%h want 6d/6d", uo9, uo15);
        end
        ui_in = 8'h21;
        repeat (3) tick();
    endtask

    task automatic test_blank();
        do_reset();
        ui_in = 8'h09;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            div_in = 1'b1; tick(); div_in = 1'b0; tick();
            n_tests++;
            if (uo9 !== 8'h00 || uo15 !== 8'h00) begin
                n_fail++;
                $display("FAIL blank step %0d: got %h/%h want 00/00", i, uo9, uo15);
            end
        end
        ui_in = 8'h01;
        repeat (3) tick();
        n_tests++;
        if (uo9 !== 8'h6D || uo15 !== 8'h6D) begin
            n_fail++;
            $display("FAIL unblank: got %h/%h want 6d/6d", uo9, uo15);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ui_in = 8'h01;
        repeat (4) tick();
        for (int i = 0; i < 7; i++) begin
            div_in = 1'b1; tick(); div_in = 1'b0; tick();
        end
        n_tests++;
        if (uo9 !== 8'h07 || uo15 !== 8'h07) begin
            n_fail++;
            $display("FAIL pre_reset_count: got %h/%h want 07/07", uo9, uo15);
        end
        ui_in = 8'h35;
        tick();
        rst_n = 1'b0;
        ui_in = 8'h00;
        tick();
        n_tests++;
        if (uo9 !== 8'h00 || uo15 !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: got %h/%h want 00/00", uo9, uo15);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            div_in = ~div_in;
            tick();
            n_tests++;
            if (uo9 !== 8'h3F || uo15 !== 8'h3F) begin
                n_fail++;
                $display("FAIL post_reset cyc %0d: got %h/%h want 3f/3f", i, uo9, uo15);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rst_n  = ($urandom_range(0, 99) != 0);
            div_in = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 3) == 0) begin
                ui_in = 8'($urandom);
            end
            tick();
            n_tests++;
            if (uo15 !== m_uo[0] || uo9 !== m_uo[1]) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h/%h want %h/%h", i, uo15, uo9, m_uo[0], m_uo[1]);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        div_in   = 1'b0;
        ui_in    = 8'h00;
        h1 = 8'h00; h2 = 8'h00; h3 = 8'h00;
        div_prev = 1'b0;
        maxv[0]  = 15;
        maxv[1]  = 9;
        for (int m = 0; m < 2; m++) begin
            m_cnt[m] = 0;
            m_dp[m]  = 1'b0;
            m_uo[m]  = 8'h00;
        end
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_blank();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
